// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe match scheduler:
// key bit indices, board cell codes, scheduler FSM states.
package ttt_pkg;

   localparam int KEY_UP    = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_LEFT  = 2;
   localparam int KEY_RIGHT = 3;
   localparam int KEY_ENTER = 4;
   localparam int KEY_SPACE = 5;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_PLAY,
      S_RESULT,
      S_OVER
   } state_t;

   function automatic logic board_full(input logic [17:0] b);
      logic f;
      f = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (b[2*i +: 2] == CELL_EMPTY) f = 1'b0;
      end
      return f;
   endfunction

endpackage

// File: rtl/ttt_key_gate.sv
// Per-player key gate: passes keys only while the player holds the
// grant and is armed; a grant change or rearm request disarms it.
// Ports: clk, reset (async, high), keys[5:0], grant, rearm, masked[5:0].
module ttt_key_gate
   import ttt_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] keys,
   input  logic       grant,
   input  logic       rearm,
   output logic [5:0] masked
);

   logic armed;

   // Arming waits for a fully released keypad so a key held across a
   // turn change never reaches the core as a fresh press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed <= 1'b0;
      end else if (!grant || rearm) begin
         armed <= 1'b0;
      end else if (keys == 6'b0) begin
         armed <= 1'b1;
      end
   end

   assign masked = keys & {6{armed}};

endmodule

// File: rtl/ttt_match_sched.sv
// Match scheduler and key arbiter in front of the tic-tac-toe core.
// Ports: clk, reset (async, high), p1_keys/p2_keys in, core_keys and
// core_reset out, core_win_flag/core_board/core_player in,
// p1_score, p2_score, round_cnt, draw_flag, match_over, match_winner out.
// Optional macro TTT_TURN_TIMEOUT_EN enables the idle-turn forfeit.
module ttt_match_sched
   import ttt_pkg::*;
#(
   parameter int ROUNDS_TO_WIN = 3,
   parameter int CLEAR_CYCLES  = 4,
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int TURN_TIMEOUT  = 250_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  p1_keys,
   input  logic [5:0]  p2_keys,
   output logic [5:0]  core_keys,
   output logic        core_reset,
   input  logic        core_win_flag,
   input  logic [17:0] core_board,
   input  logic        core_player,
   output logic [3:0]  p1_score,
   output logic [3:0]  p2_score,
   output logic [7:0]  round_cnt,
   output logic        draw_flag,
   output logic        match_over,
   output logic        match_winner
);

   localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [3:0] WIN_N = 4'(ROUNDS_TO_WIN);

   state_t state, next;

   logic [CLR_W-1:0]  clr_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic win_q, grant_q, full_q, e1_q, e2_q;
   logic full_now, win_rise, draw_now, to_hit;
   logic clr_last, hold_last, enter_rise, rearm;
   logic win_ev, draw_ev, to_ev, over_ev, restart;
   logic pt_p2;
   logic [5:0] m1, m2, gated;

   assign full_now   = board_full(core_board);
   assign win_rise   = core_win_flag & ~win_q;
   // Two full-board cycles with no win cover the core's win-check lag.
   assign draw_now   = full_now & ~core_win_flag & full_q;
   assign clr_last   = clr_cnt == CLR_W'(CLEAR_CYCLES - 1);
   assign hold_last  = hold_cnt == HOLD_W'(HOLD_CYCLES - 1);
   assign enter_rise = (p1_keys[KEY_ENTER] & ~e1_q) |
                       (p2_keys[KEY_ENTER] & ~e2_q);
   assign rearm      = (state != S_PLAY) | (core_player != grant_q);
   assign gated      = core_player ? m2 : m1;
   // A forfeit credits the player not on move.
   assign pt_p2      = to_ev ? ~core_player : core_player;

   ttt_key_gate u_gate1 (
      .clk    (clk),
      .reset  (reset),
      .keys   (p1_keys),
      .grant  (~core_player),
      .rearm  (rearm),
      .masked (m1)
   );

   ttt_key_gate u_gate2 (
      .clk    (clk),
      .reset  (reset),
      .keys   (p2_keys),
      .grant  (core_player),
      .rearm  (rearm),
      .masked (m2)
   );

`ifdef TTT_TURN_TIMEOUT_EN
   localparam int TO_W = $clog2(TURN_TIMEOUT + 1);
   logic [TO_W-1:0] turn_cnt;
   logic            turn_reload;

   assign turn_reload = (core_player != grant_q) | (core_keys != 6'b0);
   assign to_hit      = turn_cnt == TO_W'(TURN_TIMEOUT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         turn_cnt <= '0;
      end else if (state != S_PLAY || turn_reload) begin
         turn_cnt <= '0;
      end else if (!to_hit) begin
         turn_cnt <= turn_cnt + 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_CLEAR;
      else       state <= next;
   end

   always_comb begin
      next    = state;
      win_ev  = 1'b0;
      draw_ev = 1'b0;
      to_ev   = 1'b0;
      over_ev = 1'b0;
      restart = 1'b0;
      unique case (state)
         S_CLEAR: begin
            if (clr_last) next = S_PLAY;
         end
         S_PLAY: begin
            if (win_rise) begin
               win_ev = 1'b1;
               next   = S_RESULT;
            end else if (draw_now) begin
               draw_ev = 1'b1;
               next    = S_RESULT;
            end else if (to_hit) begin
               to_ev = 1'b1;
               next  = S_RESULT;
            end
         end
         S_RESULT: begin
            if (hold_last) begin
               if (p1_score == WIN_N || p2_score == WIN_N) begin
                  over_ev = 1'b1;
                  next    = S_OVER;
               end else begin
                  next = S_CLEAR;
               end
            end
         end
         S_OVER: begin
            if (enter_rise) begin
               restart = 1'b1;
               next    = S_CLEAR;
            end
         end
         default: next = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         core_keys    <= '0;
         core_reset   <= 1'b1;
         p1_score     <= '0;
         p2_score     <= '0;
         round_cnt    <= '0;
         draw_flag    <= 1'b0;
         match_over   <= 1'b0;
         match_winner <= 1'b0;
         clr_cnt      <= '0;
         hold_cnt     <= '0;
         win_q        <= 1'b0;
         grant_q      <= 1'b0;
         full_q       <= 1'b0;
         e1_q         <= 1'b0;
         e2_q         <= 1'b0;
      end else begin
         win_q   <= core_win_flag;
         grant_q <= core_player;
         full_q  <= (state == S_PLAY) & full_now & ~core_win_flag;
         e1_q    <= p1_keys[KEY_ENTER];
         e2_q    <= p2_keys[KEY_ENTER];

         core_reset <= next == S_CLEAR;
         core_keys  <= (state == S_PLAY && next == S_PLAY) ? gated : '0;

         clr_cnt  <= (state == S_CLEAR && !clr_last) ?
                     clr_cnt + 1'b1 : '0;
         hold_cnt <= (state == S_RESULT && !hold_last) ?
                     hold_cnt + 1'b1 : '0;

         if (win_ev || to_ev) begin
            if (pt_p2) begin
               if (p2_score < WIN_N) p2_score <= p2_score + 1'b1;
            end else begin
               if (p1_score < WIN_N) p1_score <= p1_score + 1'b1;
            end
         end

         if (draw_ev) draw_flag <= 1'b1;
         else if (state == S_RESULT && next != S_RESULT) draw_flag <= 1'b0;

         if ((win_ev || draw_ev || to_ev) && round_cnt != 8'hFF)
            round_cnt <= round_cnt + 1'b1;

         if (over_ev) begin
            match_over   <= 1'b1;
            match_winner <= p2_score == WIN_N;
         end

         if (restart) begin
            p1_score   <= '0;
            p2_score   <= '0;
            round_cnt  <= '0;
            match_over <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ttt_match_sched.sv
// Directed bench for ttt_match_sched: reset, arbitration, win, draw,
// match end and restart (plus idle forfeit when TTT_TURN_TIMEOUT_EN).
module tb_ttt_match_sched;
   import ttt_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  p1_keys, p2_keys, core_keys;
   logic        core_reset, core_win_flag, core_player;
   logic [17:0] core_board;
   logic [3:0]  p1_score, p2_score;
   logic [7:0]  round_cnt;
   logic        draw_flag, match_over, match_winner;

   int total = 0;
   int bad   = 0;

   localparam logic [17:0] FULL = 18'h29966;

   ttt_match_sched #(
      .ROUNDS_TO_WIN (3),
      .CLEAR_CYCLES  (4),
      .HOLD_CYCLES   (10),
      .TURN_TIMEOUT  (20)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .p1_keys       (p1_keys),
      .p2_keys       (p2_keys),
      .core_keys     (core_keys),
      .core_reset    (core_reset),
      .core_win_flag (core_win_flag),
      .core_board    (core_board),
      .core_player   (core_player),
      .p1_score      (p1_score),
      .p2_score      (p2_score),
      .round_cnt     (round_cnt),
      .draw_flag     (draw_flag),
      .match_over    (match_over),
      .match_winner  (match_winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      p1_keys = '0;
      p2_keys = '0;
      core_win_flag = 1'b0;
      core_board = '0;
      core_player = 1'b0;
      step(2);
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_core_keys", 32'(core_keys), 0);
      chk("rst_p1", 32'(p1_score), 0);
      chk("rst_p2", 32'(p2_score), 0);
      chk("rst_round", 32'(round_cnt), 0);
      chk("rst_draw", 32'(draw_flag), 0);
      chk("rst_over", 32'(match_over), 0);
      chk("rst_winner", 32'(match_winner), 0);

      // reset release: core_reset high for 4 cycles
      reset = 1'b0;
      chk("clr_c0", 32'(core_reset), 1);
      for (int i = 1; i < 4; i++) begin
         step(1);
         chk("clr_hi", 32'(core_reset), 1);
      end
      step(1);
      chk("clr_lo", 32'(core_reset), 0);
      chk("state_play", 32'(dut.state), 32'(S_PLAY));

      // non-granted keypad ignored
      p2_keys = 6'h01;
      step(2);
      chk("p2_blocked", 32'(core_keys), 0);

      // grant change with p2 holding up
      core_player = 1'b1;
      step(3);
      chk("held_blocked", 32'(core_keys), 0);
      p2_keys = 6'h00;
      step(1);
      chk("release", 32'(core_keys), 0);
      p2_keys = 6'h01;
      step(1);
      chk("p2_up_pass", 32'(core_keys), 6'h01);
      p2_keys = 6'h00;
      p1_keys = 6'h01;
      step(1);
      chk("p1_ignored", 32'(core_keys), 0);
      p1_keys = 6'h00;

      // P2 wins a round
      core_win_flag = 1'b1;
      step(1);
      core_win_flag = 1'b0;
      chk("win_p2", 32'(p2_score), 1);
      chk("win_p1", 32'(p1_score), 0);
      chk("win_round", 32'(round_cnt), 1);
      chk("win_draw", 32'(draw_flag), 0);
      chk("win_state", 32'(dut.state), 32'(S_RESULT));
      step(9);
      chk("hold_rst_lo", 32'(core_reset), 0);
      step(1);
      chk("hold_rst_hi", 32'(core_reset), 1);
      step(4);
      chk("play2_rst", 32'(core_reset), 0);

      // draw
      core_board = FULL;
      step(1);
      chk("draw_1cyc", 32'(round_cnt), 1);
      step(1);
      chk("draw_flag", 32'(draw_flag), 1);
      chk("draw_round", 32'(round_cnt), 2);
      chk("draw_p1", 32'(p1_score), 0);
      chk("draw_p2", 32'(p2_score), 1);
      core_board = '0;
      step(9);
      chk("draw_hold", 32'(draw_flag), 1);
      step(1);
      chk("draw_clr", 32'(draw_flag), 0);
      chk("draw_next", 32'(core_reset), 1);
      step(4);

      // P1 wins three rounds
      core_player = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) core_board = FULL;
         core_win_flag = 1'b1;
         step(1);
         core_win_flag = 1'b0;
         core_board = '0;
         chk("m_p1", 32'(p1_score), 32'(i + 1));
         chk("m_draw", 32'(draw_flag), 0);
         if (i < 2) begin
            step(10);
            step(4);
         end
      end
      p1_keys = 6'h10;
      step(10);
      chk("over", 32'(match_over), 1);
      chk("over_winner", 32'(match_winner), 0);
      chk("over_round", 32'(round_cnt), 5);
      chk("over_p1", 32'(p1_score), 3);
      step(2);
      chk("held_enter", 32'(match_over), 1);
      p1_keys = 6'h00;
      step(1);
      p2_keys = 6'h10;
      step(1);
      p2_keys = 6'h00;
      chk("rs_over", 32'(match_over), 0);
      chk("rs_p1", 32'(p1_score), 0);
      chk("rs_p2", 32'(p2_score), 0);
      chk("rs_round", 32'(round_cnt), 0);
      chk("rs_clear", 32'(core_reset), 1);

`ifdef TTT_TURN_TIMEOUT_EN
      step(4);
      begin
         int n;
         n = 0;
         while (p2_score != 4'd1 && n < 60) begin
            step(1);
            n++;
         end
      end
      chk("to_p2", 32'(p2_score), 1);
      chk("to_draw", 32'(draw_flag), 0);
      chk("to_round", 32'(round_cnt), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
